mash_sdm: RTL
=============

Name: mash_sdm

Overview:
Parametrised MASH 1-1-1 sigma-delta modulator for fractional-N division control. It is the next generation of the fixed three-section modulator and adds:
- runtime-selectable order (0–3)
- a step-enable strobe
- shadowed configuration
- optional LFSR dither
- integer+fraction summation with saturation into a registered divide ratio

It sits between the frequency-control registers and the programmable divider.

Parameters:
W, 16, accumulator / fractional word width (4..32)
NW, 8, integer part and div_ratio width (2..16)
DEF_ORDER, 3, active order after reset (0..3)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
en  in  1  step strobe; modulator advances on edges where en=1
cfg_load  in  1  latch frac/n_int/order/dith_on into shadow config
frac  in  W  unsigned fractional word, value frac/2^W
n_int  in  NW  unsigned integer divide part
order  in  2  requested order: 0=integer only, 1..3=MASH order
dith_on  in  1  enable LSB dither
sdm_out  out  4  signed modulator output y (two's complement)
div_ratio  out  NW  saturated n_int+y
sat  out  1  div_ratio was clamped on last step
out_valid  out  1  high one cycle after each step

Behaviour:
Reset (rstn=0, asynchronous, no clock needed):
- acc1..acc3=0; c2_d, c3_d, c3_dd=0; lfsr=15'h0001
- shadow frac=0, n_int=0, order=DEF_ORDER, dith=0
- sdm_out=0, div_ratio=0, sat=0, out_valid=0

Config:
- cfg_load sampled on every edge, independent of en; loads all four shadow fields.
- The active config is always the shadow register value.
- cfg_load and en on the same edge: the step uses the old shadow values; the new values apply from the next step.

Step (edge with en=1), all combinational within the step:
- d = lfsr[0] if dith active, else 0.
- Stage 1: {c1,acc1'} = acc1 + frac + d, (W+1)-bit sum; c1 is the carry.
- Stage 2: {c2,acc2'} = acc2 + acc1'.
- Stage 3: {c3,acc3'} = acc3 + acc2'.
- Stage k with k > order: accumulator forced to 0, carry 0, its delay registers cleared on this step.
- y = c1 + (c2 - c2_d) + (c3 - 2*c3_d + c3_dd), evaluated in 4-bit signed.
- Range of y: order1 0..1, order2 -1..2, order3 -3..4.
- Order 0: y=0 and all accumulators cleared.
- Delays update: c2_d<=c2, c3_dd<=c3_d, c3_d<=c3.
- lfsr advances: Fibonacci, x^15+x^14+1, shift left, feedback bit = lfsr[14]^lfsr[13]. It advances on every step whether or not dither is on.
- Registered outputs: sdm_out<=y. r = n_int + y computed in NW+2-bit signed. div_ratio<=clamp(r, 0, 2^NW-1). sat<=1 if clamped, else 0.
- out_valid<=1 for exactly the cycle following the step edge, 0 otherwise.
- Latency: one clock from the step edge to outputs.

No step (en=0):
- All accumulators, delays, lfsr, sdm_out, div_ratio and sat hold.
- out_valid<=0.

Accumulator wrap: modulo 2^W, carry discarded into c_k only. There is no other overflow path.

Order change at runtime: takes effect on the next step. Newly disabled stages are cleared; newly enabled stages start from 0.

Mid-run reset: everything returns to reset values immediately; the first step after release behaves as after power-up.

Test Plan:
1. W=16, order=1, frac=0x8000, n_int=10, dith off, en every cycle:
   - sdm_out sequence 0,1,0,1,...
   - div_ratio 10,11,10,11
   - out_valid high each cycle after the first step.
2. order=3, frac=0x4000, n_int=20, dith off, 65536 steps:
   - every sdm_out in [-3,4]
   - sum of sdm_out = 16384±3
   - sat never set.
3. Saturation with NW=8:
   - n_int=255, order=1, frac=0xFFFF → div_ratio=255 with sat=1 on steps where y=1.
   - n_int=0, order=3 → any y<0 gives div_ratio=0, sat=1.
4. en gating: en toggled 1-0-0-0-1 with frac=0x8000, order=1:
   - outputs and accumulators hold through en=0.
   - out_valid pulses only after the two en edges.
   - sequence continues 0,1 across the gap.
5. cfg_load with en on the same edge, frac changing 0x8000→0x0000:
   - that step still uses 0x8000.
   - subsequent steps use 0x0000; order-1 output then stays at 0 after the residual carry.
6. rstn pulsed low mid-run with no clock edge:
   - sdm_out, div_ratio, sat and out_valid are 0 immediately.
   - after release, the scenario 1 sequence reproduces exactly.
   - with dith on, the lfsr restarts at 0x0001.

Source files
------------

// File: rtl/mash_sdm_if.sv
// rtl/mash_sdm_if.sv - control/result bundle between frequency-control logic and mash_sdm
//
// Purpose : groups the step/config inputs and the registered modulator results.
// Signals : en, cfg_load, frac[W], n_int[NW], order[2], dith_on   (controller -> modulator)
//           sdm_out[4], div_ratio[NW], sat, out_valid            (modulator -> divider)
// Modports: master = controller side, slave = modulator side.
interface mash_sdm_if #(
    parameter int W  = 16,
    parameter int NW = 8
);
    logic          en;
    logic          cfg_load;
    logic [W-1:0]  frac;
    logic [NW-1:0] n_int;
    logic [1:0]    order;
    logic          dith_on;
    logic [3:0]    sdm_out;
    logic [NW-1:0] div_ratio;
    logic          sat;
    logic          out_valid;

    modport master (
        output en, cfg_load, frac, n_int, order, dith_on,
        input  sdm_out, div_ratio, sat, out_valid
    );

    modport slave (
        input  en, cfg_load, frac, n_int, order, dith_on,
        output sdm_out, div_ratio, sat, out_valid
    );
endinterface

// File: rtl/mash_sdm.sv
// rtl/mash_sdm.sv - MASH 1-1-1 sigma-delta modulator with runtime order, dither and saturated divide ratio
//
// Purpose : each enabled step advances up to three cascaded accumulators, forms the
//           MASH noise-shaped output y, and registers clamp(n_int + y) as the divide ratio.
// Ports   : clk      - clock
//           rstn     - asynchronous active-low reset
//           bus      - mash_sdm_if.slave (en, cfg_load, frac, n_int, order, dith_on in;
//                      sdm_out, div_ratio, sat, out_valid out)
// Params  : W (accumulator width), NW (integer/div_ratio width), DEF_ORDER (order after reset)
module mash_sdm #(
    parameter int W         = 16,
    parameter int NW        = 8,
    parameter int DEF_ORDER = 3
) (
    input  logic      clk,
    input  logic      rstn,
    mash_sdm_if.slave bus
);

    // Shadow configuration; the datapath only ever sees these copies.
    logic [W-1:0]  r_frac;
    logic [NW-1:0] r_n_int;
    logic [1:0]    r_order;
    logic          r_dith;

    // Modulator state
    logic [W-1:0]  r_acc1, r_acc2, r_acc3;
    logic          r_c2_d, r_c3_d, r_c3_dd;
    logic [14:0]   r_lfsr;

    // Registered outputs
    logic [3:0]    r_sdm_out;
    logic [NW-1:0] r_div_ratio;
    logic          r_sat;
    logic          r_out_valid;

    // Step datapath
    logic                 w_en1, w_en2, w_en3;
    logic                 w_d;
    logic [W:0]           w_s1, w_s2, w_s3;
    logic [W-1:0]         w_acc1, w_acc2, w_acc3;
    logic                 w_c1, w_c2, w_c3;
    logic                 w_c2d_e, w_c3d_e, w_c3dd_e;
    logic signed [3:0]    w_y;
    logic signed [NW+1:0] w_r;
    logic [NW-1:0]        w_div;
    logic                 w_sat;

    always_comb begin
        w_en1 = (r_order >= 2'd1);
        w_en2 = (r_order >= 2'd2);
        w_en3 = (r_order == 2'd3);

        w_d = r_dith & r_lfsr[0];

        w_s1   = {1'b0, r_acc1} + {1'b0, r_frac} + {{W{1'b0}}, w_d};
        w_acc1 = w_en1 ? w_s1[W-1:0] : '0;
        w_c1   = w_en1 & w_s1[W];

        w_s2   = {1'b0, r_acc2} + {1'b0, w_acc1};
        w_acc2 = w_en2 ? w_s2[W-1:0] : '0;
        w_c2   = w_en2 & w_s2[W];

        w_s3   = {1'b0, r_acc3} + {1'b0, w_acc2};
        w_acc3 = w_en3 ? w_s3[W-1:0] : '0;
        w_c3   = w_en3 & w_s3[W];

        // A disabled stage contributes nothing, including stale delay bits left
        // over from before an order reduction.
        w_c2d_e  = w_en2 & r_c2_d;
        w_c3d_e  = w_en3 & r_c3_d;
        w_c3dd_e = w_en3 & r_c3_dd;

        w_y = 4'(w_c1) + 4'(w_c2) - 4'(w_c2d_e)
            + 4'(w_c3) - {2'b00, w_c3d_e, 1'b0} + 4'(w_c3dd_e);

        // Two guard bits: one for the sign of y, one for n_int + 4 overflowing NW bits.
        w_r = $signed({2'b00, r_n_int}) + (NW+2)'(w_y);

        if (w_r[NW+1]) begin
            w_div = '0;
            w_sat = 1'b1;
        end else if (w_r[NW]) begin
            w_div = '1;
            w_sat = 1'b1;
        end else begin
            w_div = w_r[NW-1:0];
            w_sat = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_frac      <= '0;
            r_n_int     <= '0;
            r_order     <= 2'(DEF_ORDER);
            r_dith      <= 1'b0;
            r_acc1      <= '0;
            r_acc2      <= '0;
            r_acc3      <= '0;
            r_c2_d      <= 1'b0;
            r_c3_d      <= 1'b0;
            r_c3_dd     <= 1'b0;
            r_lfsr      <= 15'h0001;
            r_sdm_out   <= '0;
            r_div_ratio <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.en;

            // Same-edge load lands after this step has consumed the old shadow.
            if (bus.cfg_load) begin
                r_frac  <= bus.frac;
                r_n_int <= bus.n_int;
                r_order <= bus.order;
                r_dith  <= bus.dith_on;
            end

            if (bus.en) begin
                r_acc1      <= w_acc1;
                r_acc2      <= w_acc2;
                r_acc3      <= w_acc3;
                r_c2_d      <= w_c2;
                r_c3_dd     <= w_en3 ? r_c3_d : 1'b0;
                r_c3_d      <= w_c3;
                r_lfsr      <= {r_lfsr[13:0], r_lfsr[14] ^ r_lfsr[13]};
                r_sdm_out   <= w_y;
                r_div_ratio <= w_div;
                r_sat       <= w_sat;
            end
        end
    end

    assign bus.sdm_out   = r_sdm_out;
    assign bus.div_ratio = r_div_ratio;
    assign bus.sat       = r_sat;
    assign bus.out_valid = r_out_valid;

endmodule
